// File: rtl/cmd_dispatch.sv
// Host command dispatcher: packs CMD_BYTES host bytes into a word and writes it to a storage-queue slot.
// Latency: the last byte accepted in cycle N gives sq_select in cycle N+2 when the queue has room.
// Backpressure: host_cmd_ready is high only while collecting. A full queue holds the command until a slot frees.
// Optional feature: define CMD_PARITY_EN to check even parity on every host byte.
module cmd_dispatch #(
   parameter int CMD_BYTES      = 8,
   parameter int MAX_CMDQ_DEPTH = 32
) (
   input  logic                     clock_fpga,
   input  logic                     reset,
   input  logic                     host_cmd_valid,
   input  logic [7:0]               host_cmd_data,
   input  logic                     host_cmd_parity,
   output logic                     host_cmd_ready,
   output logic                     sq_select,
   output logic [8*CMD_BYTES-1:0]   sq_cmd,
   output logic [7:0]               sq_slot,
   input  logic                     status_update_enable,
   output logic [7:0]               sq_count,
   output logic                     err_illegal,
   output logic                     err_parity
);

   localparam int              IDX_W    = $clog2(CMD_BYTES);
   localparam int              TAIL_W   = $clog2(MAX_CMDQ_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_BYTES - 1);
   localparam logic [7:0]      FULL_CNT = 8'(MAX_CMDQ_DEPTH);

   typedef enum logic [1:0] {S_COLLECT, S_CHECK, S_ISSUE, S_STALL} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [IDX_W-1:0]        byte_idx;
   logic [TAIL_W-1:0]       tail;
   logic [7:0]              count;
   logic [8*CMD_BYTES-1:0]  cmd_word;
   logic                    par_bad;
   logic                    accept;
   logic                    opcode_ok;
   logic                    retire;

   assign accept    = host_cmd_valid && host_cmd_ready;
   assign opcode_ok = (cmd_word[7:0] == 8'h01) || (cmd_word[7:0] == 8'h02) ||
                      (cmd_word[7:0] == 8'h03);
   // A completion with nothing outstanding is dropped so the count never underflows.
   assign retire    = status_update_enable && (count != 8'd0);

`ifdef CMD_PARITY_EN
   // Sticky parity error across one command; cleared when the next command's opcode byte arrives.
   always_ff @(posedge clock_fpga) begin
      if (reset) begin
         par_bad <= 1'b0;
      end else if (accept) begin
         par_bad <= ((byte_idx == '0) ? 1'b0 : par_bad) | (^host_cmd_data ^ host_cmd_parity);
      end
   end
`else
   logic unused_parity;
   assign unused_parity = host_cmd_parity;
   assign par_bad       = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock_fpga) begin
      if (reset) state <= S_COLLECT;
      else       state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_COLLECT: if (accept && (byte_idx == LAST_IDX)) state_nxt = S_CHECK;
         S_CHECK: begin
            if (par_bad || !opcode_ok)  state_nxt = S_COLLECT;
            else if (count == FULL_CNT) state_nxt = S_STALL;
            else                        state_nxt = S_ISSUE;
         end
         S_ISSUE:   state_nxt = S_COLLECT;
         S_STALL:   if (status_update_enable) state_nxt = S_ISSUE;
         default:   state_nxt = S_COLLECT;
      endcase
   end

   // Outputs are gated by reset so nothing leaks out while reset is held.
   always_comb begin
      host_cmd_ready = 1'b0;
      sq_select      = 1'b0;
      err_illegal    = 1'b0;
      err_parity     = 1'b0;
      if (!reset) begin
         host_cmd_ready = (state == S_COLLECT);
         sq_select      = (state == S_ISSUE);
         err_parity     = (state == S_CHECK) && par_bad;
         err_illegal    = (state == S_CHECK) && !par_bad && !opcode_ok;
      end
   end

   // Byte index and command assembly, little-endian from byte 0.
   always_ff @(posedge clock_fpga) begin
      if (reset) begin
         byte_idx <= '0;
         cmd_word <= '0;
      end else if (accept) begin
         cmd_word[8*int'(byte_idx) +: 8] <= host_cmd_data;
         byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
      end
   end

   // Tail pointer advances after each issue and wraps at the queue depth.
   always_ff @(posedge clock_fpga) begin
      if (reset)          tail <= '0;
      else if (sq_select) tail <= tail + 1'b1;
   end

   // Outstanding-slot count: an issue and a completion in the same cycle cancel.
   always_ff @(posedge clock_fpga) begin
      if (reset) begin
         count <= 8'd0;
      end else begin
         case ({sq_select, retire})
            2'b10:   count <= count + 8'd1;
            2'b01:   count <= count - 8'd1;
            default: count <= count;
         endcase
      end
   end

   assign sq_cmd   = reset ? '0    : cmd_word;
   assign sq_slot  = reset ? 8'd0  : 8'(tail);
   assign sq_count = reset ? 8'd0  : count;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch.
// Random and directed commands are checked against a queue-level model of count, tail and issue timing.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled at the same point.
module tb_cmd_dispatch;

   localparam int CB    = 8;
   localparam int DEPTH = 32;

   logic              clock_fpga = 1'b0;
   logic              reset;
   logic              host_cmd_valid;
   logic [7:0]        host_cmd_data;
   logic              host_cmd_parity;
   logic              host_cmd_ready;
   logic              sq_select;
   logic [8*CB-1:0]   sq_cmd;
   logic [7:0]        sq_slot;
   logic              status_update_enable;
   logic [7:0]        sq_count;
   logic              err_illegal;
   logic              err_parity;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_count;
   int exp_tail;

   cmd_dispatch #(.CMD_BYTES(CB), .MAX_CMDQ_DEPTH(DEPTH)) dut (
      .clock_fpga           (clock_fpga),
      .reset                (reset),
      .host_cmd_valid       (host_cmd_valid),
      .host_cmd_data        (host_cmd_data),
      .host_cmd_parity      (host_cmd_parity),
      .host_cmd_ready       (host_cmd_ready),
      .sq_select            (sq_select),
      .sq_cmd               (sq_cmd),
      .sq_slot              (sq_slot),
      .status_update_enable (status_update_enable),
      .sq_count             (sq_count),
      .err_illegal          (err_illegal),
      .err_parity           (err_parity)
   );

   always #5 clock_fpga = ~clock_fpga;

   task automatic tick();
      @(posedge clock_fpga);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Present one byte and wait (bounded) until it is accepted.
   task automatic send_byte(input logic [7:0] d, input logic p);
      int t = 0;
      host_cmd_valid  = 1'b1;
      host_cmd_data   = d;
      host_cmd_parity = p;
      while (!host_cmd_ready && t < 64) begin
         tick();
         t++;
      end
      if (t >= 64) check("accept_timeout", 64'(t), 64'd0);
      tick();
      host_cmd_valid = 1'b0;
   endtask

   // Send a full command. A byte index in bad_byte gets inverted parity. seq selects the 0x11.. payload.
   task automatic send_cmd(input logic [7:0] op, input int bad_byte, input bit seq,
                           output logic [63:0] word);
      logic [7:0] d;
      logic       p;
      word = '0;
      for (int k = 0; k < CB; k++) begin
         if (k == 0)   d = op;
         else if (seq) d = 8'(8'h10 + k);
         else          d = 8'($urandom_range(0, 255));
         p = ^d;
         if (k == bad_byte) p = ~p;
         word = word | (64'(d) << (8 * k));
         send_byte(d, p);
      end
   endtask

   // Called in the cycle after the last byte is accepted. It predicts drop, stall or issue from the rules.
   task automatic finish_cmd(input logic [7:0] op, input int bad_byte, input logic [63:0] word,
                             input bit sue_in_issue);
      bit par_fail;
      bit op_ok;
`ifdef CMD_PARITY_EN
      par_fail = (bad_byte >= 0);
`else
      par_fail = 1'b0;
`endif
      op_ok = (op == 8'h01) || (op == 8'h02) || (op == 8'h03);
      check("check_ready", 64'(host_cmd_ready), 64'd0);
      check("check_err_parity", 64'(err_parity), 64'(par_fail));
      check("check_err_illegal", 64'(err_illegal), 64'(!par_fail && !op_ok));
      check("check_no_select", 64'(sq_select), 64'd0);
      if (par_fail || !op_ok) begin
         tick();
         check("drop_err_one_cycle", 64'(err_illegal | err_parity), 64'd0);
         check("drop_no_select", 64'(sq_select), 64'd0);
         check("drop_ready", 64'(host_cmd_ready), 64'd1);
         check("drop_count", 64'(sq_count), 64'(exp_count));
         return;
      end
      if (exp_count == DEPTH) begin
         repeat (3) begin
            tick();
            check("stall_no_select", 64'(sq_select), 64'd0);
            check("stall_ready", 64'(host_cmd_ready), 64'd0);
         end
         status_update_enable = 1'b1;
         tick();
         status_update_enable = 1'b0;
         exp_count--;
      end else begin
         tick();
      end
      check("issue_select", 64'(sq_select), 64'd1);
      check("issue_slot", 64'(sq_slot), 64'(exp_tail));
      check("issue_cmd", sq_cmd, word);
      check("issue_count", 64'(sq_count), 64'(exp_count));
      if (sue_in_issue) status_update_enable = 1'b1;
      tick();
      status_update_enable = 1'b0;
      if (!(sue_in_issue && exp_count > 0)) exp_count++;
      exp_tail = (exp_tail + 1) % DEPTH;
      check("post_select_low", 64'(sq_select), 64'd0);
      check("post_count", 64'(sq_count), 64'(exp_count));
      check("post_cmd_hold", sq_cmd, word);
      check("post_ready", 64'(host_cmd_ready), 64'd1);
   endtask

   // One standalone completion pulse while idle.
   task automatic retire_one();
      status_update_enable = 1'b1;
      tick();
      status_update_enable = 1'b0;
      if (exp_count > 0) exp_count--;
      check("retire_count", 64'(sq_count), 64'(exp_count));
   endtask

   initial begin
      logic [63:0] w;
      logic [7:0]  op;

      reset                = 1'b1;
      host_cmd_valid       = 1'b0;
      host_cmd_data        = 8'h00;
      host_cmd_parity      = 1'b0;
      status_update_enable = 1'b0;
      repeat (3) tick();

      check("rst_ready", 64'(host_cmd_ready), 64'd0);
      check("rst_select", 64'(sq_select), 64'd0);
      check("rst_errs", 64'(err_illegal | err_parity), 64'd0);
      check("rst_count", 64'(sq_count), 64'd0);
      check("rst_slot", 64'(sq_slot), 64'd0);
      check("rst_cmd", sq_cmd, 64'd0);

      reset = 1'b0;
      #1;
      check("ready_after_reset", 64'(host_cmd_ready), 64'd1);
      exp_count = 0;
      exp_tail  = 0;
      tick();

      // Directed command 0x02, 0x11..0x17.
      send_cmd(8'h02, -1, 1'b1, w);
      check("directed_word", w, 64'h1716151413121102);
      finish_cmd(8'h02, -1, w, 1'b0);

      // Fill the queue with random valid commands, with illegal opcodes mixed in.
      while (exp_count < DEPTH) begin
         if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(4, 255));
         else                           op = 8'($urandom_range(1, 3));
         send_cmd(op, -1, 1'b0, w);
         finish_cmd(op, -1, w, 1'b0);
      end
      check("full_count", 64'(sq_count), 64'(DEPTH));

      // The 33rd command stalls and then issues to wrapped slot 0 after one completion.
      op = 8'($urandom_range(1, 3));
      send_cmd(op, -1, 1'b0, w);
      finish_cmd(op, -1, w, 1'b0);
      check("stall_then_full", 64'(sq_count), 64'(DEPTH));

      // Drain to 5, then issue with a simultaneous completion.
      while (exp_count > 5) retire_one();
      send_cmd(8'h01, -1, 1'b0, w);
      finish_cmd(8'h01, -1, w, 1'b1);
      check("simul_count_5", 64'(sq_count), 64'd5);

      // Drain to 0, then send a completion with nothing outstanding.
      while (exp_count > 0) retire_one();
      retire_one();
      check("no_underflow", 64'(sq_count), 64'd0);

      // Illegal opcode 0x7F.
      send_cmd(8'h7F, -1, 1'b0, w);
      finish_cmd(8'h7F, -1, w, 1'b0);

      // Reset after three bytes discards the partial command.
      for (int k = 0; k < 3; k++) send_byte(8'(8'h02 + k), ^(8'(8'h02 + k)));
      reset = 1'b1;
      tick();
      tick();
      check("midcmd_rst_ready", 64'(host_cmd_ready), 64'd0);
      check("midcmd_rst_count", 64'(sq_count), 64'd0);
      reset = 1'b0;
      exp_count = 0;
      exp_tail  = 0;
      tick();
      send_cmd(8'h03, -1, 1'b0, w);
      finish_cmd(8'h03, -1, w, 1'b0);

      // Reset while the command sits in CHECK suppresses the pending issue.
      send_cmd(8'h02, -1, 1'b0, w);
      reset = 1'b1;
      tick();
      check("rst_suppress_select", 64'(sq_select), 64'd0);
      reset = 1'b0;
      exp_count = 0;
      exp_tail  = 0;
      #1;
      check("rst_suppress_ready", 64'(host_cmd_ready), 64'd1);
      check("rst_suppress_count", 64'(sq_count), 64'd0);
      tick();
      check("rst_suppress_no_late_select", 64'(sq_select), 64'd0);

      // Bad parity on byte 4: dropped when parity checking is built in, issued otherwise.
      send_cmd(8'h02, 4, 1'b0, w);
      finish_cmd(8'h02, 4, w, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
